pipeline_hazard_unit: RTL and testbench

//  Drives the decode/execute pipeline register's bubble input and the fetch/decode hold/flush controls.

---
 rtl/pipeline_hazard_unit_pkg.sv | 27 ++
 rtl/pipeline_hazard_unit_compare.sv | 33 +++
 rtl/pipeline_hazard_unit.sv | 139 +++++++++++++
 tb/tb_pipeline_hazard_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_unit_pkg.sv
// Shared pipeline definitions: hazard FSM states, forwarding select encoding
// and the rule that picks a forwarding source from per-stage match results.
package pipeline_hazard_unit_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } hz_state_t;

  // Names describe where the operand is taken from once the consumer is in execute.
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  localparam int REG_ZERO = 0;

  // The younger producer (execute) wins over the older one (memory).
  function automatic fwd_sel_t fwd_pick(input logic ex_hit, input logic mem_hit);
    if (ex_hit)       return FWD_MEM;
    else if (mem_hit) return FWD_WB;
    else              return FWD_RF;
  endfunction

endpackage

// File: rtl/pipeline_hazard_unit_compare.sv
// Source-vs-destination match for both decode sources against the execute
// and memory producers. R0 never matches, so it never stalls or forwards.
module pipeline_hazard_unit_compare
  import pipeline_hazard_unit_pkg::*;
#(
  parameter int REG_W = 4
) (
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic [REG_W-1:0] rd_execute,
  input  logic             wre_execute,
  input  logic [REG_W-1:0] rd_memory,
  input  logic             wre_memory,
  output logic             hit1_execute,
  output logic             hit2_execute,
  output logic             hit1_memory,
  output logic             hit2_memory
);

  localparam logic [REG_W-1:0] ZERO = REG_W'(REG_ZERO);

  logic ex_live;
  logic mem_live;

  assign ex_live  = wre_execute && (rd_execute != ZERO);
  assign mem_live = wre_memory  && (rd_memory  != ZERO);

  assign hit1_execute = ex_live  && (rd_execute == rs1);
  assign hit2_execute = ex_live  && (rd_execute == rs2);
  assign hit1_memory  = mem_live && (rd_memory  == rs1);
  assign hit2_memory  = mem_live && (rd_memory  == rs2);

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Load-use stall / taken-branch flush sequencer with Mealy pipeline controls,
// registered forwarding selects and saturating stall/flush cycle counters.
module pipeline_hazard_unit
  import pipeline_hazard_unit_pkg::*;
#(
  parameter int REG_W      = 4,
  parameter int LOAD_STALL = 1,
  parameter int FLUSH_CYC  = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             decode_valid,
  input  logic [REG_W-1:0] rs1_decode,
  input  logic [REG_W-1:0] rs2_decode,
  input  logic [REG_W-1:0] rd_execute,
  input  logic             wre_execute,
  input  logic             load_instruction,
  input  logic [REG_W-1:0] rd_memory,
  input  logic             wre_memory,
  input  logic             branch_taken_execute,
  output logic             stall_fetch,
  output logic             flush_decode,
  output logic             nop_select,
  output logic [1:0]       fwd_a_execute,
  output logic [1:0]       fwd_b_execute,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [2:0]       STALL_INIT = 3'(LOAD_STALL - 1);
  localparam logic [2:0]       FLUSH_INIT = 3'(FLUSH_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  hz_state_t state;
  logic [2:0] cnt;
  fwd_sel_t  fwd_a_q;
  fwd_sel_t  fwd_b_q;

  logic hit1_ex, hit2_ex, hit1_mem, hit2_mem;
  logic lu;

  pipeline_hazard_unit_compare #(.REG_W(REG_W)) u_compare (
    .rs1          (rs1_decode),
    .rs2          (rs2_decode),
    .rd_execute   (rd_execute),
    .wre_execute  (wre_execute),
    .rd_memory    (rd_memory),
    .wre_memory   (wre_memory),
    .hit1_execute (hit1_ex),
    .hit2_execute (hit2_ex),
    .hit1_memory  (hit1_mem),
    .hit2_memory  (hit2_mem)
  );

  assign lu = decode_valid && load_instruction && (hit1_ex || hit2_ex);

  // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
  always_comb begin
    stall_fetch  = 1'b0;
    flush_decode = 1'b0;
    nop_select   = 1'b0;
    if (!reset) begin
      unique case (state)
        RUN, STALL: begin
          if (branch_taken_execute) begin
            flush_decode = 1'b1;
            nop_select   = 1'b1;
          end else if (state == STALL || lu) begin
            stall_fetch = 1'b1;
            nop_select  = 1'b1;
          end
        end
        FLUSH: begin
          flush_decode = 1'b1;
          nop_select   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      cnt         <= 3'd0;
      fwd_a_q     <= FWD_RF;
      fwd_b_q     <= FWD_RF;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      unique case (state)
        RUN, STALL: begin
          if (branch_taken_execute) begin
            // A branch aborts any pending stall sequence.
            if (FLUSH_CYC > 1) begin
              state <= FLUSH;
              cnt   <= FLUSH_INIT;
            end else begin
              state <= RUN;
              cnt   <= 3'd0;
            end
          end else if (state == STALL) begin
            cnt <= cnt - 3'd1;
            if (cnt == 3'd1) state <= RUN;
          end else if (lu && LOAD_STALL > 1) begin
            state <= STALL;
            cnt   <= STALL_INIT;
          end
        end
        FLUSH: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) state <= RUN;
        end
        default: begin
          state <= RUN;
          cnt   <= 3'd0;
        end
      endcase

      // Bubbles and empty decode slots carry no operands, so they never forward.
      if (nop_select || !decode_valid) begin
        fwd_a_q <= FWD_RF;
        fwd_b_q <= FWD_RF;
      end else begin
        fwd_a_q <= fwd_pick(hit1_ex && !load_instruction, hit1_mem);
        fwd_b_q <= fwd_pick(hit2_ex && !load_instruction, hit2_mem);
      end

      if (stall_fetch && stall_count != CNT_MAX) stall_count <= stall_count + CNT_W'(1);
      if (flush_decode && flush_count != CNT_MAX) flush_count <= flush_count + CNT_W'(1);
    end
  end

  assign fwd_a_execute = fwd_a_q;
  assign fwd_b_execute = fwd_b_q;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Drives a default build and a LOAD_STALL=3 build with shared stimulus and
// checks both against a pending-bubble reference model every cycle.
module tb_pipeline_hazard_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       decode_valid;
  logic [3:0] rs1_decode, rs2_decode, rd_execute, rd_memory;
  logic       wre_execute, load_instruction, wre_memory, branch_taken_execute;

  logic        st_w [2];
  logic        fl_w [2];
  logic        np_w [2];
  logic [1:0]  fa_w [2];
  logic [1:0]  fb_w [2];
  logic [15:0] sc_w [2];
  logic [15:0] fc_w [2];

  int total = 0;
  int bad   = 0;

  // Reference model state: bubbles still owed after the current cycle.
  int ls_p [2] = '{1, 3};
  int fc_p [2] = '{2, 2};
  int pend_stall [2];
  int pend_flush [2];
  int m_sc [2];
  int m_fc [2];
  int m_fa [2];
  int m_fb [2];

  always #5 clk = ~clk;

  pipeline_hazard_unit #(.REG_W(4), .LOAD_STALL(1), .FLUSH_CYC(2), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .decode_valid(decode_valid),
    .rs1_decode(rs1_decode), .rs2_decode(rs2_decode),
    .rd_execute(rd_execute), .wre_execute(wre_execute), .load_instruction(load_instruction),
    .rd_memory(rd_memory), .wre_memory(wre_memory), .branch_taken_execute(branch_taken_execute),
    .stall_fetch(st_w[0]), .flush_decode(fl_w[0]), .nop_select(np_w[0]),
    .fwd_a_execute(fa_w[0]), .fwd_b_execute(fb_w[0]),
    .stall_count(sc_w[0]), .flush_count(fc_w[0])
  );

  pipeline_hazard_unit #(.REG_W(4), .LOAD_STALL(3), .FLUSH_CYC(2), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset), .decode_valid(decode_valid),
    .rs1_decode(rs1_decode), .rs2_decode(rs2_decode),
    .rd_execute(rd_execute), .wre_execute(wre_execute), .load_instruction(load_instruction),
    .rd_memory(rd_memory), .wre_memory(wre_memory), .branch_taken_execute(branch_taken_execute),
    .stall_fetch(st_w[1]), .flush_decode(fl_w[1]), .nop_select(np_w[1]),
    .fwd_a_execute(fa_w[1]), .fwd_b_execute(fb_w[1]),
    .stall_count(sc_w[1]), .flush_count(fc_w[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int src_of(input int rs);
    if (wre_execute && rd_execute != 0 && int'(rd_execute) == rs && !load_instruction) return 1;
    if (wre_memory && rd_memory != 0 && int'(rd_memory) == rs) return 2;
    return 0;
  endfunction

  // One clock: compare Mealy controls mid-cycle, then registered outputs after the edge.
  task automatic step(input bit chk);
    bit lu, e_st, e_fl;
    @(negedge clk); #1;
    lu = decode_valid && load_instruction && wre_execute && rd_execute != 0 &&
         (rd_execute == rs1_decode || rd_execute == rs2_decode);
    for (int k = 0; k < 2; k++) begin
      e_st = 1'b0;
      e_fl = 1'b0;
      if (reset) begin
        pend_stall[k] = 0;
        pend_flush[k] = 0;
      end else if (pend_flush[k] > 0) begin
        e_fl = 1'b1;
        pend_flush[k]--;
      end else if (branch_taken_execute) begin
        e_fl = 1'b1;
        pend_flush[k] = fc_p[k] - 1;
        pend_stall[k] = 0;
      end else if (pend_stall[k] > 0) begin
        e_st = 1'b1;
        pend_stall[k]--;
      end else if (lu) begin
        e_st = 1'b1;
        pend_stall[k] = ls_p[k] - 1;
      end
      if (chk) begin
        check($sformatf("stall_fetch[%0d]", k), 32'(st_w[k]), 32'(e_st));
        check($sformatf("flush_decode[%0d]", k), 32'(fl_w[k]), 32'(e_fl));
        check($sformatf("nop_select[%0d]", k), 32'(np_w[k]), 32'(e_st | e_fl));
      end
      if (reset) begin
        m_sc[k] = 0; m_fc[k] = 0; m_fa[k] = 0; m_fb[k] = 0;
      end else begin
        if (e_st && m_sc[k] < 65535) m_sc[k]++;
        if (e_fl && m_fc[k] < 65535) m_fc[k]++;
        m_fa[k] = (e_st || e_fl || !decode_valid) ? 0 : src_of(int'(rs1_decode));
        m_fb[k] = (e_st || e_fl || !decode_valid) ? 0 : src_of(int'(rs2_decode));
      end
    end
    @(posedge clk); #1;
    if (chk) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("fwd_a[%0d]", k), 32'(fa_w[k]), 32'(m_fa[k]));
        check($sformatf("fwd_b[%0d]", k), 32'(fb_w[k]), 32'(m_fb[k]));
        check($sformatf("stall_count[%0d]", k), 32'(sc_w[k]), 32'(m_sc[k]));
        check($sformatf("flush_count[%0d]", k), 32'(fc_w[k]), 32'(m_fc[k]));
      end
    end
  endtask

  task automatic idle();
    reset = 1'b0; decode_valid = 1'b0;
    rs1_decode = 4'd0; rs2_decode = 4'd0; rd_execute = 4'd0; rd_memory = 4'd0;
    wre_execute = 1'b0; load_instruction = 1'b0; wre_memory = 1'b0;
    branch_taken_execute = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step(1'b1);
    reset = 1'b0;
  endtask

  initial begin
    idle();
    do_reset();
    check("reset stall_count", 32'(sc_w[0]), 32'd0);
    check("reset fwd_a", 32'(fa_w[0]), 32'd0);

    // Load r3 in execute, decode reads r3; then the load sits in memory.
    decode_valid = 1'b1; rs1_decode = 4'd3; rs2_decode = 4'd7;
    rd_execute = 4'd3; wre_execute = 1'b1; load_instruction = 1'b1;
    step(1'b1);
    check("lu fwd_a during bubble", 32'(fa_w[0]), 32'd0);
    rd_execute = 4'd0; wre_execute = 1'b0; load_instruction = 1'b0;
    rd_memory = 4'd3; wre_memory = 1'b1;
    step(1'b1);
    check("lu stall_count", 32'(sc_w[0]), 32'd1);
    check("lu fwd_a after", 32'(fa_w[0]), 32'd2);

    // ALU result in execute forwards from memory stage; R0 never forwards.
    idle(); decode_valid = 1'b1; rs2_decode = 4'd5; rd_execute = 4'd5; wre_execute = 1'b1;
    step(1'b1);
    check("alu fwd_b", 32'(fb_w[0]), 32'd1);
    rs2_decode = 4'd0; rd_execute = 4'd0;
    step(1'b1);
    check("r0 fwd_b", 32'(fb_w[0]), 32'd0);

    // Taken branch: two flush cycles.
    do_reset();
    branch_taken_execute = 1'b1;
    step(1'b1);
    branch_taken_execute = 1'b0;
    step(1'b1);
    step(1'b1);
    check("branch flush_count", 32'(fc_w[0]), 32'd2);

    // Branch together with a load-use hazard: flush only.
    do_reset();
    decode_valid = 1'b1; rs1_decode = 4'd4; rd_execute = 4'd4;
    wre_execute = 1'b1; load_instruction = 1'b1; branch_taken_execute = 1'b1;
    step(1'b1);
    branch_taken_execute = 1'b0;
    step(1'b1);
    check("br+lu stall_count0", 32'(sc_w[0]), 32'd0);
    check("br+lu stall_count1", 32'(sc_w[1]), 32'd0);
    check("br+lu flush_count", 32'(fc_w[1]), 32'd2);

    // LOAD_STALL=3: one hazard yields three stall cycles.
    do_reset();
    decode_valid = 1'b1; rs2_decode = 4'd9; rd_execute = 4'd9;
    wre_execute = 1'b1; load_instruction = 1'b1;
    step(1'b1);
    idle(); decode_valid = 1'b1; rs2_decode = 4'd9; rd_memory = 4'd9; wre_memory = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1);
    check("ls3 stall_count", 32'(sc_w[1]), 32'd3);
    check("ls1 stall_count", 32'(sc_w[0]), 32'd1);

    // Reset in the second stall cycle abandons the sequence.
    do_reset();
    decode_valid = 1'b1; rs1_decode = 4'd2; rd_execute = 4'd2;
    wre_execute = 1'b1; load_instruction = 1'b1;
    step(1'b1);
    idle(); reset = 1'b1;
    step(1'b1);
    reset = 1'b0;
    step(1'b1);
    check("mid-stall reset count", 32'(sc_w[1]), 32'd0);

    // Randomized traffic over a small register range so matches are frequent.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset                = ($urandom_range(49) == 0);
      decode_valid         = 1'($urandom);
      rs1_decode           = 4'($urandom_range(3));
      rs2_decode           = 4'($urandom_range(3));
      rd_execute           = 4'($urandom_range(3));
      rd_memory            = 4'($urandom_range(3));
      wre_execute          = 1'($urandom);
      wre_memory           = 1'($urandom);
      load_instruction     = ($urandom_range(2) == 0);
      branch_taken_execute = ($urandom_range(7) == 0);
      step(1'b1);
    end

    // Saturation: a hazard held long enough to overflow a 16-bit count.
    do_reset();
    decode_valid = 1'b1; rs1_decode = 4'd6; rd_execute = 4'd6;
    wre_execute = 1'b1; load_instruction = 1'b1;
    for (int i = 0; i < 65540; i++) step(1'b0);
    step(1'b1);
    check("sat stall_count0", 32'(sc_w[0]), 32'h0000_FFFF);
    check("sat stall_count1", 32'(sc_w[1]), 32'h0000_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
